clk_verify_div_prog: RTL
========================

Name: clk_verify_div_prog

Overview:
- Programmable, fully synchronous successor to the fixed 2^11 ripple observation divider.
- Generates a 50%-duty observation clock at a selectable ratio of 2^(div_sel+1), in continuous or fixed-length burst mode.
- Counts output edges for on-chip readback of clock activity.
- Sits between the core clock and the observation pad buffer chain; the buffer chain stays external.

Parameters:
- CNT_W, 16: half-period counter width; maximum divide ratio 2^CNT_W.
- SEL_W, 4: width of div_sel.
- BURST_W, 8: width of burst_len and the burst period counter.
- EDGE_W, 16: width of edge_cnt.

Ports:
- clk  in  1  core clock to be observed; sole clock.
- rst  in  1  synchronous reset, active-high.
- en  in  1  run enable; gates both modes.
- mode  in  1  0 = continuous, 1 = burst.
- div_sel  in  SEL_W  half period H = 2^min(div_sel, CNT_W-1) clk cycles.
- burst_len  in  BURST_W  number of full output periods per burst.
- start  in  1  burst trigger pulse (mode 1 only).
- cnt_clr  in  1  synchronous clear of edge_cnt.
- clk_div_out  out  1  registered divided clock.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse at normal burst completion.
- edge_cnt  out  EDGE_W  rising edges of clk_div_out, saturating.

Behaviour:
- Reset (rst=1 at an edge): state=IDLE, clk_div_out=0, busy=0, done=0, edge_cnt=0, internal counters=0. Applies mid-operation, overrides everything, and produces no done.
- States: IDLE, RUN, STOP.
- IDLE:
  - clk_div_out=0, half-period counter held at 0.
  - mode=0 and en=1 -> RUN.
  - mode=1 and en=1 and start=1 -> RUN, latching burst_len.
  - Burst with burst_len=0 -> stays IDLE, done=1 next cycle, no output pulse.
- RUN, half-period timing:
  - Counter increments each cycle.
  - At count H_act-1: counter -> 0 and clk_div_out toggles.
  - First rising edge occurs H_act cycles after RUN entry. Output is exactly H_act low, then H_act high.
- div_sel handling:
  - div_sel is sampled into sel_act on IDLE->RUN and at every falling toggle (end of a full period).
  - A change mid-period takes effect from the next period only; no truncated or stretched half-periods.
- Burst mode:
  - Period counter increments at each falling toggle.
  - At the falling toggle completing period burst_len: -> IDLE, done=1 that cycle (the same edge at which clk_div_out goes 0).
- en=0 in RUN:
  - If clk_div_out=0 -> IDLE on the next edge.
  - If clk_div_out=1 -> STOP.
- STOP: keep counting until the natural falling toggle, then IDLE. The high pulse is never truncated. Burst aborted this way gives no done.
- start while busy is ignored. mode and burst_len changes while busy are ignored; they are sampled only in IDLE.
- edge_cnt:
  - +1 on every 0->1 toggle of clk_div_out; saturates at all-ones.
  - cnt_clr=1 forces 0 and takes priority over a simultaneous increment.
- div_sel >= CNT_W is clamped to CNT_W-1.
- All outputs are registered; no combinational path from inputs to outputs.

Test Plan:
- Continuous, div_sel=0, en=1 from cycle 0 -> clk_div_out period 2 (1 high/1 low); after 100 cycles edge_cnt=50±1; busy=1.
- Continuous, div_sel=3 -> 8 low/8 high. Change div_sel to 1 mid-high-phase -> current period completes at 8/8, then 2/2.
- div_sel=2, drop en 1 cycle into the high phase -> high phase lasts the full 4 cycles, then IDLE, busy=0, output stays 0.
- Burst, div_sel=1, burst_len=3, start pulse -> exactly 3 rising edges (2 high/2 low each). done pulses once, on the cycle of the 3rd falling edge. edge_cnt=3. A second start mid-burst is ignored.
- Burst with burst_len=0 -> no output edge, done=1 one cycle after start. rst asserted mid-burst -> all outputs 0 next cycle, no done.
- CNT_W=4, EDGE_W=3, div_sel=9 -> clamped H=8. After 8 rising edges edge_cnt=7 (saturated). cnt_clr together with a rising edge -> edge_cnt=0.

Source files
------------

// File: rtl/clk_verify_div_prog.sv
// clk_verify_div_prog: programmable observation clock divider.
//
// Produces a 50%-duty divided clock whose half period is H = 2^min(div_sel, CNT_W-1)
// core cycles. It runs either continuously or for a fixed number of full periods.
// Rising edges of the output are counted for on-chip readback. The pad buffer chain
// lives outside this block.
//
// Ports:
//   clk          core clock being observed (sole clock)
//   rst          synchronous reset, active-high
//   en           run enable for both modes
//   mode         0 = continuous, 1 = burst
//   div_sel      half-period select (clamped to CNT_W-1)
//   burst_len    full output periods per burst (0 = empty burst, done only)
//   start        burst trigger pulse, honoured in IDLE only
//   cnt_clr      synchronous clear of edge_cnt
//   clk_div_out  registered divided clock
//   busy         high whenever the divider is not idle
//   done         one-cycle pulse when a burst completes normally
//   edge_cnt     saturating count of clk_div_out rising edges
module clk_verify_div_prog #(
   parameter int unsigned CNT_W   = 16,
   parameter int unsigned SEL_W   = 4,
   parameter int unsigned BURST_W = 8,
   parameter int unsigned EDGE_W  = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic               mode,
   input  logic [SEL_W-1:0]   div_sel,
   input  logic [BURST_W-1:0] burst_len,
   input  logic               start,
   input  logic               cnt_clr,
   output logic               clk_div_out,
   output logic               busy,
   output logic               done,
   output logic [EDGE_W-1:0]  edge_cnt
);

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StStop
   } state_e;

   localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               out_q, out_d;
   logic [SEL_W-1:0]   sel_q, sel_d;
   logic               burst_q, burst_d;
   logic [BURST_W-1:0] len_q, len_d;
   logic [BURST_W-1:0] per_q, per_d;
   logic               done_q, done_d;
   logic [EDGE_W-1:0]  edge_q, edge_d;

   logic [SEL_W-1:0]   sel_clamped;
   logic [CNT_W-1:0]   half_m1;
   logic [BURST_W-1:0] per_inc;
   logic               term;
   logic               rise;

   // sel_q always holds an already-clamped value, so the shift never overflows.
   always_comb begin
      if (32'(div_sel) > CNT_W - 1) begin
         sel_clamped = SEL_W'(CNT_W - 1);
      end else begin
         sel_clamped = div_sel;
      end
   end

   assign half_m1 = (CntOne << sel_q) - CntOne;
   assign term    = (cnt_q == half_m1);
   assign per_inc = per_q + BURST_W'(1);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      out_d   = out_q;
      sel_d   = sel_q;
      burst_d = burst_q;
      len_d   = len_q;
      per_d   = per_q;
      done_d  = 1'b0;
      rise    = 1'b0;

      unique case (state_q)
         StIdle: begin
            cnt_d = '0;
            out_d = 1'b0;
            per_d = '0;
            if (en && !mode) begin
               state_d = StRun;
               sel_d   = sel_clamped;
               burst_d = 1'b0;
            end else if (en && mode && start) begin
               if (burst_len == '0) begin
                  // Empty burst: report completion without leaving IDLE.
                  done_d = 1'b1;
               end else begin
                  state_d = StRun;
                  sel_d   = sel_clamped;
                  burst_d = 1'b1;
                  len_d   = burst_len;
               end
            end
         end

         StRun: begin
            if (!en && !out_q) begin
               // Low phase can be cut short without producing a runt pulse.
               state_d = StIdle;
               cnt_d   = '0;
            end else begin
               cnt_d = term ? '0 : cnt_q + CntOne;
               if (term) begin
                  out_d = !out_q;
                  if (!out_q) begin
                     rise = 1'b1;
                  end else begin
                     // Falling toggle closes a full period; pick up the new ratio here.
                     sel_d = sel_clamped;
                     per_d = per_inc;
                     if (!en) begin
                        state_d = StIdle;
                     end else if (burst_q && (per_inc == len_q)) begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                     end
                  end
               end else if (!en) begin
                  // High phase in progress: finish it before going idle.
                  state_d = StStop;
               end
            end
         end

         StStop: begin
            cnt_d = term ? '0 : cnt_q + CntOne;
            if (term) begin
               out_d   = 1'b0;
               state_d = StIdle;
            end
         end

         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_comb begin
      edge_d = edge_q;
      if (cnt_clr) begin
         edge_d = '0;
      end else if (rise && (edge_q != '1)) begin
         edge_d = edge_q + EDGE_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         out_q   <= 1'b0;
         sel_q   <= '0;
         burst_q <= 1'b0;
         len_q   <= '0;
         per_q   <= '0;
         done_q  <= 1'b0;
         edge_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         out_q   <= out_d;
         sel_q   <= sel_d;
         burst_q <= burst_d;
         len_q   <= len_d;
         per_q   <= per_d;
         done_q  <= done_d;
         edge_q  <= edge_d;
      end
   end

   assign clk_div_out = out_q;
   assign busy        = (state_q != StIdle);
   assign done        = done_q;
   assign edge_cnt    = edge_q;

endmodule
